// File: rtl/region_drawer.sv
// region_drawer: streams a rectangular block of ROM pixels onto the VGA pixel bus,
// one ROM address per clock, with colour-key transparency and screen clipping.
module region_drawer #(
  parameter int X_W         = 8,
  parameter int Y_W         = 8,
  parameter int ADDR_W      = 16,
  parameter int RGB_W       = 24,
  parameter int ROM_LATENCY = 2,
  parameter int SCREEN_W    = 160,
  parameter int SCREEN_H    = 120
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [X_W-1:0]    dst_x,
  input  logic [Y_W-1:0]    dst_y,
  input  logic [X_W-1:0]    width,
  input  logic [Y_W-1:0]    height,
  input  logic              key_en,
  input  logic [RGB_W-1:0]  key_rgb,
  input  logic [RGB_W-1:0]  rom_data,
  output logic [ADDR_W-1:0] rom_address,
  output logic [X_W-1:0]    vga_x,
  output logic [Y_W-1:0]    vga_y,
  output logic [RGB_W-1:0]  vga_rgb,
  output logic              vga_draw_enable,
  output logic              active,
  output logic              done
);

  // Coordinates carry one extra bit so dst + offset never wraps before clipping.
  localparam int XC_W  = X_W + 1;
  localparam int YC_W  = Y_W + 1;
  // The drain phase lasts ROM_LATENCY+1 cycles so the final output register
  // cycle still belongs to the active window.
  localparam int CNT_W = $clog2(ROM_LATENCY + 2);
  localparam logic [CNT_W-1:0] DRAIN_LAST   = CNT_W'(ROM_LATENCY);
  localparam logic [XC_W-1:0]  SCREEN_X_LIM = XC_W'(SCREEN_W);
  localparam logic [YC_W-1:0]  SCREEN_Y_LIM = YC_W'(SCREEN_H);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  state_t state;
  state_t next_state;

  logic [X_W-1:0]   dst_x_q;
  logic [Y_W-1:0]   dst_y_q;
  logic [X_W-1:0]   width_q;
  logic [Y_W-1:0]   height_q;
  logic             key_en_q;
  logic [RGB_W-1:0] key_rgb_q;
  logic [X_W-1:0]   cx;
  logic [Y_W-1:0]   cy;
  logic [CNT_W-1:0] drain_cnt;

  logic             accept;
  logic             last_col;
  logic             last_row;
  logic             last_pixel;

  logic             push_valid;
  logic [XC_W-1:0]  push_x;
  logic [YC_W-1:0]  push_y;

  logic             dl_valid [ROM_LATENCY];
  logic [XC_W-1:0]  dl_x     [ROM_LATENCY];
  logic [YC_W-1:0]  dl_y     [ROM_LATENCY];

  logic             tail_valid;
  logic [XC_W-1:0]  tail_x;
  logic [YC_W-1:0]  tail_y;
  logic             on_screen;
  logic             keyed;

  assign last_col   = (cx == width_q - X_W'(1));
  assign last_row   = (cy == height_q - Y_W'(1));
  assign last_pixel = last_col && last_row;

  assign push_valid = (state == ISSUE);
  assign push_x     = {1'b0, dst_x_q} + {1'b0, cx};
  assign push_y     = {1'b0, dst_y_q} + {1'b0, cy};

  assign tail_valid = dl_valid[ROM_LATENCY-1];
  assign tail_x     = dl_x[ROM_LATENCY-1];
  assign tail_y     = dl_y[ROM_LATENCY-1];
  assign on_screen  = (tail_x < SCREEN_X_LIM) && (tail_y < SCREEN_Y_LIM);
  assign keyed      = key_en_q && (rom_data == key_rgb_q);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode plus the bus-ownership and completion flags.
  always_comb begin
    next_state = state;
    active     = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if ((width == '0) || (height == '0)) begin
            next_state = DONE;
          end else begin
            next_state = ISSUE;
            accept     = 1'b1;
          end
        end
      end
      ISSUE: begin
        active = 1'b1;
        if (last_pixel) begin
          next_state = DRAIN;
        end
      end
      DRAIN: begin
        active = 1'b1;
        if (drain_cnt == DRAIN_LAST) begin
          next_state = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Request latch, pixel walk counters and the ROM address generator.
  always_ff @(posedge clk) begin
    if (reset) begin
      dst_x_q     <= '0;
      dst_y_q     <= '0;
      width_q     <= '0;
      height_q    <= '0;
      key_en_q    <= 1'b0;
      key_rgb_q   <= '0;
      cx          <= '0;
      cy          <= '0;
      drain_cnt   <= '0;
      rom_address <= '0;
    end else if (accept) begin
      dst_x_q     <= dst_x;
      dst_y_q     <= dst_y;
      width_q     <= width;
      height_q    <= height;
      key_en_q    <= key_en;
      key_rgb_q   <= key_rgb;
      cx          <= '0;
      cy          <= '0;
      drain_cnt   <= '0;
      rom_address <= src_base;
    end else if (state == ISSUE) begin
      drain_cnt <= '0;
      if (last_pixel) begin
        rom_address <= '0;
      end else begin
        rom_address <= rom_address + ADDR_W'(1);
      end
      if (last_col) begin
        cx <= '0;
        cy <= cy + Y_W'(1);
      end else begin
        cx <= cx + X_W'(1);
      end
    end else if (state == DRAIN) begin
      drain_cnt   <= drain_cnt + CNT_W'(1);
      rom_address <= '0;
    end else begin
      rom_address <= '0;
    end
  end

  // Delay line that keeps each pixel's coordinates aligned with its ROM word.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ROM_LATENCY; i++) begin
        dl_valid[i] <= 1'b0;
        dl_x[i]     <= '0;
        dl_y[i]     <= '0;
      end
    end else begin
      dl_valid[0] <= push_valid;
      dl_x[0]     <= push_x;
      dl_y[0]     <= push_y;
      for (int i = 1; i < ROM_LATENCY; i++) begin
        dl_valid[i] <= dl_valid[i-1];
        dl_x[i]     <= dl_x[i-1];
        dl_y[i]     <= dl_y[i-1];
      end
    end
  end

  // Output register: every valid pixel updates position and colour; only
  // visible, non-transparent pixels raise the write strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      vga_x           <= '0;
      vga_y           <= '0;
      vga_rgb         <= '0;
      vga_draw_enable <= 1'b0;
    end else begin
      vga_draw_enable <= tail_valid && on_screen && !keyed;
      if (tail_valid) begin
        vga_x   <= tail_x[X_W-1:0];
        vga_y   <= tail_y[Y_W-1:0];
        vga_rgb <= rom_data;
      end
    end
  end

endmodule

// File: tb/tb_region_drawer.sv
// tb_region_drawer: randomized and directed checks of region_drawer against a
// cycle-indexed arithmetic model, on a ROM_LATENCY=2 and a ROM_LATENCY=4 instance.
module tb_region_drawer;

  localparam int LAT_A = 2;
  localparam int LAT_B = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic [15:0] src_base = '0;
  logic [7:0]  dst_x = '0;
  logic [7:0]  dst_y = '0;
  logic [7:0]  width = '0;
  logic [7:0]  height = '0;
  logic        key_en = 1'b0;
  logic [23:0] key_rgb = '0;

  logic [23:0] rom_data_a, rom_data_b;
  logic [15:0] rom_address_a, rom_address_b;
  logic [7:0]  vga_x_a, vga_x_b, vga_y_a, vga_y_b;
  logic [23:0] vga_rgb_a, vga_rgb_b;
  logic        draw_a, draw_b, active_a, active_b, done_a, done_b;

  logic [23:0] rom_mem [0:65535];
  logic [23:0] pipe_a [LAT_A];
  logic [23:0] pipe_b [LAT_B];

  logic        sel_b = 1'b0;
  logic [15:0] obs_addr;
  logic [7:0]  obs_x, obs_y;
  logic [23:0] obs_rgb;
  logic        obs_draw, obs_active, obs_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  region_drawer #(.ROM_LATENCY(LAT_A)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .src_base(src_base),
    .dst_x(dst_x), .dst_y(dst_y), .width(width), .height(height),
    .key_en(key_en), .key_rgb(key_rgb), .rom_data(rom_data_a),
    .rom_address(rom_address_a), .vga_x(vga_x_a), .vga_y(vga_y_a),
    .vga_rgb(vga_rgb_a), .vga_draw_enable(draw_a), .active(active_a), .done(done_a)
  );

  region_drawer #(.ROM_LATENCY(LAT_B)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .src_base(src_base),
    .dst_x(dst_x), .dst_y(dst_y), .width(width), .height(height),
    .key_en(key_en), .key_rgb(key_rgb), .rom_data(rom_data_b),
    .rom_address(rom_address_b), .vga_x(vga_x_b), .vga_y(vga_y_b),
    .vga_rgb(vga_rgb_b), .vga_draw_enable(draw_b), .active(active_b), .done(done_b)
  );

  // ROM models with fixed read latency per instance.
  always @(posedge clk) begin
    pipe_a[0] <= rom_mem[rom_address_a];
    for (int i = 1; i < LAT_A; i++) pipe_a[i] <= pipe_a[i-1];
    pipe_b[0] <= rom_mem[rom_address_b];
    for (int i = 1; i < LAT_B; i++) pipe_b[i] <= pipe_b[i-1];
  end
  assign rom_data_a = pipe_a[LAT_A-1];
  assign rom_data_b = pipe_b[LAT_B-1];

  assign obs_addr   = sel_b ? rom_address_b : rom_address_a;
  assign obs_x      = sel_b ? vga_x_b : vga_x_a;
  assign obs_y      = sel_b ? vga_y_b : vga_y_a;
  assign obs_rgb    = sel_b ? vga_rgb_b : vga_rgb_a;
  assign obs_draw   = sel_b ? draw_b : draw_a;
  assign obs_active = sel_b ? active_b : active_a;
  assign obs_done   = sel_b ? done_b : done_a;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Runs one region draw on the selected instance. Cycle t means t cycles after
  // the edge that samples start. reset_at>0 asserts reset for the edge ending
  // cycle t=reset_at; busy_at>0 pulses start then; junk scrambles the inputs
  // and throws in extra start pulses while the block is busy.
  task automatic applyStimulus(input bit use_b, input logic [15:0] base,
                               input logic [7:0] dx, input logic [7:0] dy,
                               input logic [7:0] w, input logic [7:0] h,
                               input logic ken, input logic [23:0] krgb,
                               input int reset_at, input int busy_at, input bit junk);
    int lat, n, t_done, t_end, k, px, py;
    bit zero, killed, pix, exp_active, exp_done, exp_draw;
    logic [23:0] prgb;
    string who;
    who = use_b ? "L4" : "L2";
    lat = use_b ? LAT_B : LAT_A;
    n = int'(w) * int'(h);
    zero = (n == 0);
    t_done = zero ? 1 : n + lat + 2;
    t_end = (reset_at > 0) ? reset_at + 3 : t_done + 2;

    @(negedge clk);
    sel_b = use_b;
    src_base = base; dst_x = dx; dst_y = dy; width = w; height = h;
    key_en = ken; key_rgb = krgb;
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk);

    for (int t = 1; t <= t_end; t++) begin
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
      killed = (reset_at > 0) && (t > reset_at);
      exp_active = !killed && !zero && (t <= n + lat + 1);
      exp_done = !killed && (t == t_done);
      k = t - 2 - lat;
      pix = !killed && !zero && (k >= 0) && (k < n);
      px = 0; py = 0; prgb = '0; exp_draw = 1'b0;
      if (pix) begin
        px = int'(dx) + (k % int'(w));
        py = int'(dy) + (k / int'(w));
        prgb = rom_mem[(int'(base) + k) & 16'hFFFF];
        exp_draw = (px < 160) && (py < 120) && !(ken && (prgb == krgb));
      end
      checkOutput($sformatf("%s active t=%0d", who, t), 32'(obs_active), 32'(exp_active));
      checkOutput($sformatf("%s done t=%0d", who, t), 32'(obs_done), 32'(exp_done));
      checkOutput($sformatf("%s draw t=%0d", who, t), 32'(obs_draw), 32'(exp_draw));
      if (!exp_active)
        checkOutput($sformatf("%s idle addr t=%0d", who, t), 32'(obs_addr), 32'd0);
      else if (t <= n)
        checkOutput($sformatf("%s addr t=%0d", who, t), 32'(obs_addr),
                    32'((int'(base) + t - 1) & 16'hFFFF));
      if (pix) begin
        checkOutput($sformatf("%s x t=%0d", who, t), 32'(obs_x), 32'(px & 8'hFF));
        checkOutput($sformatf("%s y t=%0d", who, t), 32'(obs_y), 32'(py & 8'hFF));
        checkOutput($sformatf("%s rgb t=%0d", who, t), 32'(obs_rgb), 32'(prgb));
      end
      if (junk) begin
        src_base = 16'($urandom); dst_x = 8'($urandom); dst_y = 8'($urandom);
        width = 8'($urandom); height = 8'($urandom);
        key_en = 1'($urandom); key_rgb = 24'($urandom);
      end
      reset = (t == reset_at);
      if ((t == busy_at) ||
          (junk && (t <= t_done) && ((reset_at == 0) || (t < reset_at)) &&
           ($urandom_range(0, 3) == 0))) begin
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
      end
    end
    start_a = 1'b0;
    start_b = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    int w, h, lat, n, rst;
    logic [15:0] base;
    logic [7:0] dx, dy;
    bit ken, use_b;
    logic [23:0] krgb;

    for (int i = 0; i < 65536; i++) rom_mem[i] = 24'($urandom);
    for (int i = 0; i < 8; i++) rom_mem[16'h0100 + i] = 24'h100000 + 24'(i * 16'h0101);
    rom_mem[16'h0102] = 24'hFF00FF;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset addr", 32'({rom_address_a, rom_address_b}), 32'd0);
    checkOutput("reset vga_x", 32'({vga_x_a, vga_x_b}), 32'd0);
    checkOutput("reset vga_y", 32'({vga_y_a, vga_y_b}), 32'd0);
    checkOutput("reset rgb a", 32'(vga_rgb_a), 32'd0);
    checkOutput("reset rgb b", 32'(vga_rgb_b), 32'd0);
    checkOutput("reset flags", 32'({draw_a, draw_b, active_a, active_b, done_a, done_b}), 32'd0);
    reset = 1'b0;

    $display("[TB] directed: basic, transparency, clipping, degenerate, reset, latency 4");
    applyStimulus(1'b0, 16'h0100, 8'd10, 8'd20, 8'd4, 8'd2, 1'b0, 24'hFF00FF, 0, 0, 1'b0);
    applyStimulus(1'b0, 16'h0100, 8'd10, 8'd20, 8'd4, 8'd2, 1'b1, 24'hFF00FF, 0, 0, 1'b0);
    applyStimulus(1'b0, 16'h0100, 8'd158, 8'd119, 8'd4, 8'd2, 1'b0, 24'h0, 0, 0, 1'b0);
    applyStimulus(1'b0, 16'h0100, 8'd10, 8'd20, 8'd0, 8'd2, 1'b0, 24'h0, 0, 0, 1'b0);
    applyStimulus(1'b0, 16'h0100, 8'd10, 8'd20, 8'd4, 8'd2, 1'b0, 24'h0, 3, 0, 1'b0);
    applyStimulus(1'b0, 16'h0100, 8'd10, 8'd20, 8'd4, 8'd2, 1'b0, 24'h0, 0, 0, 1'b0);
    applyStimulus(1'b1, 16'h0100, 8'd10, 8'd20, 8'd4, 8'd2, 1'b0, 24'h0, 0, 5, 1'b0);

    $display("[TB] randomized regions");
    for (int r = 0; r < 60; r++) begin
      use_b = 1'($urandom);
      lat = use_b ? LAT_B : LAT_A;
      base = ($urandom_range(0, 5) == 0) ? 16'(16'hFFF8 + $urandom_range(0, 7)) : 16'($urandom);
      dx = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(150, 255)) : 8'($urandom_range(0, 255));
      dy = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(112, 255)) : 8'($urandom_range(0, 255));
      w = $urandom_range(0, 6);
      h = $urandom_range(0, 4);
      n = w * h;
      ken = 1'($urandom);
      krgb = ($urandom_range(0, 1) == 0) ? rom_mem[(int'(base) + $urandom_range(0, 3)) & 16'hFFFF]
                                         : 24'($urandom);
      rst = 0;
      if ((n > 0) && ($urandom_range(0, 7) == 0)) rst = $urandom_range(1, n + lat + 1);
      applyStimulus(use_b, base, dx, dy, 8'(w), 8'(h), ken, krgb, rst, 0, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
